sh_reg: RTL and testbench



---
 rtl/sh_reg_if.sv | 32 +++
 rtl/sh_reg.sv | 74 +++++++
 tb/tb_sh_reg.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sh_reg_if.sv
// Operand-register bus for sh_reg: control, fill and load data in, contents out.
// sh_out exists only when SH_REG_SHOUT_EN is defined.
interface sh_reg_if #(
    parameter int unsigned w = 8,
    parameter int unsigned d = 1
);
    logic         load;
    logic         sh;
    logic [2:0]   sh_mode;
    logic [d-1:0] sh_in;
    logic [w-1:0] in;
    logic [w-1:0] q;
`ifdef SH_REG_SHOUT_EN
    logic [d-1:0] sh_out;
`endif

    modport master (
        output load, sh, sh_mode, sh_in, in,
`ifdef SH_REG_SHOUT_EN
        input  sh_out,
`endif
        input  q
    );

    modport slave (
        input  load, sh, sh_mode, sh_in, in,
`ifdef SH_REG_SHOUT_EN
        output sh_out,
`endif
        output q
    );
endinterface

// File: rtl/sh_reg.sv
// Loadable shift register moving d bits per shift in one of 8 shift/rotate modes.
// Optional SH_REG_SHOUT_EN adds a registered sh_out of the bits shifted out.
module sh_reg #(
    parameter int unsigned w = 8,
    parameter int unsigned d = 1
) (
    input  logic     clk,
    input  logic     rst_b,
    sh_reg_if.slave  bus
);
    typedef enum logic [2:0] {
        ModeShl = 3'b000,
        ModeShr = 3'b001,
        ModeLsl = 3'b010,
        ModeLsr = 3'b011,
        ModeAsr = 3'b100,
        ModeRol = 3'b101,
        ModeRor = 3'b110,
        ModeNop = 3'b111
    } mode_e;

    if (w < 2 || d < 1 || d >= w) begin : g_param_check
        $fatal(1, "sh_reg: illegal parameters w=%0d d=%0d (need 1 <= d < w)", w, d);
    end

    logic [w-1:0] r_q;
    logic [w-1:0] w_shifted;

    always_comb begin
        w_shifted = r_q;
        unique case (mode_e'(bus.sh_mode))
            ModeShl: w_shifted = {r_q[w-d-1:0], bus.sh_in};
            ModeShr: w_shifted = {bus.sh_in, r_q[w-1:d]};
            ModeLsl: w_shifted = {r_q[w-d-1:0], {d{1'b0}}};
            ModeLsr: w_shifted = {{d{1'b0}}, r_q[w-1:d]};
            ModeAsr: w_shifted = {{d{r_q[w-1]}}, r_q[w-1:d]};
            ModeRol: w_shifted = {r_q[w-d-1:0], r_q[w-1:w-d]};
            ModeRor: w_shifted = {r_q[d-1:0], r_q[w-1:d]};
            ModeNop: w_shifted = r_q;
        endcase
    end

    // Priority: reset > load > shift > hold.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_q <= '0;
        end else if (bus.load) begin
            r_q <= bus.in;
        end else if (bus.sh) begin
            r_q <= w_shifted;
        end
    end

    assign bus.q = r_q;

`ifdef SH_REG_SHOUT_EN
    logic [d-1:0] r_sh_out;

    // Captures the pre-shift bits that fall off the end; rotates count too.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_sh_out <= '0;
        end else if (!bus.load && bus.sh) begin
            unique case (mode_e'(bus.sh_mode))
                ModeShl, ModeLsl, ModeRol:          r_sh_out <= r_q[w-1:w-d];
                ModeShr, ModeLsr, ModeAsr, ModeRor: r_sh_out <= r_q[d-1:0];
                ModeNop:                            r_sh_out <= r_sh_out;
            endcase
        end
    end

    assign bus.sh_out = r_sh_out;
`endif
endmodule

// File: tb/tb_sh_reg.sv
// Self-checking bench for sh_reg in the w=8,d=1 and w=32,d=3 configurations.
// Define SH_REG_SHOUT_EN for both RTL and bench to also check sh_out.
module tb_sh_reg;
    logic clk = 1'b0;
    logic rst8;
    logic rst32;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sh_reg_if #(.w(8),  .d(1)) if8  ();
    sh_reg_if #(.w(32), .d(3)) if32 ();

    sh_reg #(.w(8),  .d(1)) dut8  (.clk(clk), .rst_b(rst8),  .bus(if8.slave));
    sh_reg #(.w(32), .d(3)) dut32 (.clk(clk), .rst_b(rst32), .bus(if32.slave));

    logic [63:0] m8;
    logic [63:0] m32;
    logic [63:0] so8;
    logic [63:0] so32;

    // Reference: arithmetic view of each mode on an unsigned w-bit value.
    function automatic logic [63:0] ref_shift(input logic [63:0] q, input int w, input int d,
                                              input int mode, input logic [63:0] fill);
        logic [63:0] mask;
        logic [63:0] top;
        mask = (64'd1 << w) - 64'd1;
        top  = mask & ~(mask >> d);
        case (mode)
            0:       return ((q << d) | fill) & mask;
            1:       return (q >> d) | (fill << (w - d));
            2:       return (q << d) & mask;
            3:       return q >> d;
            4:       return q[w-1] ? ((q >> d) | top) : (q >> d);
            5:       return ((q << d) | (q >> (w - d))) & mask;
            6:       return (q >> d) | ((q << (w - d)) & mask);
            default: return q;
        endcase
    endfunction

    function automatic logic [63:0] ref_out(input logic [63:0] q, input logic [63:0] old,
                                            input int w, input int d, input int mode);
        if (mode == 0 || mode == 2 || mode == 5) return q >> (w - d);
        if (mode == 7) return old;
        return q & ((64'd1 << d) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step8(input logic r, input logic ld, input logic s, input logic [2:0] mode,
                         input logic [0:0] fill, input logic [7:0] din, input string tag);
        rst8 = r; if8.load = ld; if8.sh = s; if8.sh_mode = mode; if8.sh_in = fill; if8.in = din;
        @(posedge clk);
        #1;
        if (r) begin
            m8 = 0; so8 = 0;
        end else if (ld) begin
            m8 = {56'd0, din};
        end else if (s) begin
            so8 = ref_out(m8, so8, 8, 1, int'(mode));
            m8  = ref_shift(m8, 8, 1, int'(mode), {63'd0, fill});
        end
        chk(tag, {56'd0, if8.q}, m8);
`ifdef SH_REG_SHOUT_EN
        chk({tag, "_shout"}, {63'd0, if8.sh_out}, so8);
`endif
        rst8 = 1'b0; if8.load = 1'b0; if8.sh = 1'b0;
    endtask

    task automatic step32(input logic r, input logic ld, input logic s, input logic [2:0] mode,
                          input logic [2:0] fill, input logic [31:0] din, input string tag);
        rst32 = r; if32.load = ld; if32.sh = s; if32.sh_mode = mode; if32.sh_in = fill;
        if32.in = din;
        @(posedge clk);
        #1;
        if (r) begin
            m32 = 0; so32 = 0;
        end else if (ld) begin
            m32 = {32'd0, din};
        end else if (s) begin
            so32 = ref_out(m32, so32, 32, 3, int'(mode));
            m32  = ref_shift(m32, 32, 3, int'(mode), {61'd0, fill});
        end
        chk(tag, {32'd0, if32.q}, m32);
`ifdef SH_REG_SHOUT_EN
        chk({tag, "_shout"}, {61'd0, if32.sh_out}, so32);
`endif
        rst32 = 1'b0; if32.load = 1'b0; if32.sh = 1'b0;
    endtask

    initial begin
        m8 = 0; m32 = 0; so8 = 0; so32 = 0;
        rst8 = 1'b1; rst32 = 1'b1;
        if8.load = 1'b0;  if8.sh = 1'b0;  if8.sh_mode = 3'd0;  if8.sh_in = '0;  if8.in = '0;
        if32.load = 1'b0; if32.sh = 1'b0; if32.sh_mode = 3'd0; if32.sh_in = '0; if32.in = '0;
        @(posedge clk);
        #1;
        rst32 = 1'b0;
        chk("reset32", {32'd0, if32.q}, 64'h0);

        // w=8,d=1 directed
        step8(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h96, "rst_over_load");
        chk("rst_over_load_lit", {56'd0, if8.q}, 64'h00);
        step8(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h96, "load96");
        chk("load96_lit", {56'd0, if8.q}, 64'h96);
        step8(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, "asr8");
        chk("asr8_lit", {56'd0, if8.q}, 64'hCB);
        step8(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h96, "reload1");
        step8(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'h00, "shl_fill8");
        chk("shl_fill8_lit", {56'd0, if8.q}, 64'h2D);
        step8(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h96, "reload2");
        step8(1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 8'h00, "ror8");
        chk("ror8_lit", {56'd0, if8.q}, 64'h4B);
        step8(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h96, "reload3");
        step8(1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 8'h00, "nop8");
        chk("nop8_lit", {56'd0, if8.q}, 64'h96);
        step8(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, "hold8");
        chk("hold8_lit", {56'd0, if8.q}, 64'h96);
        step8(1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 8'h55, "load_over_sh");
        chk("load_over_sh_lit", {56'd0, if8.q}, 64'h55);
        step8(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 8'hAA, "rst_all");
        chk("rst_all_lit", {56'd0, if8.q}, 64'h00);
`ifdef SH_REG_SHOUT_EN
        step8(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h96, "reload4");
        step8(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, "lsl8");
        chk("lsl8_lit", {56'd0, if8.q}, 64'h2C);
        chk("lsl8_shout_lit", {63'd0, if8.sh_out}, 64'h1);
        step8(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, "lsr8");
        chk("lsr8_lit", {56'd0, if8.q}, 64'h16);
        chk("lsr8_shout_lit", {63'd0, if8.sh_out}, 64'h0);
`endif

        // w=32,d=3 directed
        step32(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 32'h80000001, "load32a");
        step32(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 32'h0, "rol32");
        chk("rol32_lit", {32'd0, if32.q}, 64'h0000000C);
        step32(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 32'h80000001, "load32b");
        step32(1'b0, 1'b0, 1'b1, 3'd1, 3'b101, 32'h0, "shr_fill32");
        chk("shr_fill32_lit", {32'd0, if32.q}, 64'hB0000000);
        step32(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 32'h80000001, "load32c");
        step32(1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 32'h0, "asr32");
        chk("asr32_lit", {32'd0, if32.q}, 64'hF0000000);
        step32(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 32'h80000001, "load32d");
        step32(1'b0, 1'b0, 1'b1, 3'd3, 3'd7, 32'h0, "lsr32");
        chk("lsr32_lit", {32'd0, if32.q}, 64'h10000000);

        // Randomized runs against the reference model
        for (int i = 0; i < 50; i++) begin
            step8(($urandom_range(15) == 0), ($urandom_range(4) == 0), 1'($urandom),
                  3'($urandom), 1'($urandom), 8'($urandom), $sformatf("rand8_%0d", i));
            checks++;
            assert (!$isunknown(if8.q)) else begin
                errors++;
                $error("FAIL xcheck8_%0d observed=%h expected=known", i, if8.q);
            end
        end
        for (int i = 0; i < 50; i++) begin
            step32(($urandom_range(15) == 0), ($urandom_range(4) == 0), 1'($urandom),
                   3'($urandom), 3'($urandom), 32'($urandom), $sformatf("rand32_%0d", i));
            checks++;
            assert (!$isunknown(if32.q)) else begin
                errors++;
                $error("FAIL xcheck32_%0d observed=%h expected=known", i, if32.q);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
